ps2_rd_arbiter: RTL

- Shares the single PS2 receiver read port (rd_en / rd_vld / rd_data, 24-bit packet) between two consumers, e.g. the seven-segment controller and the processor bus interface.
- Sequences the receiver: rd_en is asserted only while a requester holds a grant. Each captured packet goes to exactly one requester.
- Round-robin arbitration, per-grant watchdog timeout, and a saturating count of packets that arrive with no grant.

---
 rtl/ps2_rd_arbiter_if.sv | 25 ++
 rtl/ps2_rd_arbiter.sv | 118 +++++++++++
 2 files changed

// File: rtl/ps2_rd_arbiter_if.sv
// Bus bundle between the PS2 read arbiter, its two requesters and the PS2 receiver.
// The slave modport is the arbiter's view; master is the environment's view.
interface ps2_rd_arbiter_if #(
    parameter int DATA_W = 24
);
    logic [1:0]        req;
    logic [1:0]        gnt;
    logic [1:0]        pkt_vld;
    logic [DATA_W-1:0] pkt_data;
    logic [1:0]        timeout;
    logic              rd_en;
    logic              rd_vld;
    logic [DATA_W-1:0] rd_data;
    logic [7:0]        drop_cnt;

    modport slave (
        input  req, rd_vld, rd_data,
        output gnt, pkt_vld, pkt_data, timeout, rd_en, drop_cnt
    );

    modport master (
        output req, rd_vld, rd_data,
        input  gnt, pkt_vld, pkt_data, timeout, rd_en, drop_cnt
    );
endinterface

// File: rtl/ps2_rd_arbiter.sv
// Round-robin arbiter sharing one PS2 receiver read port between two consumers,
// with a per-grant watchdog and a saturating count of unrequested packets.
module ps2_rd_arbiter #(
    parameter int DATA_W      = 24,
    parameter int TIMEOUT_CYC = 1000000,
    parameter int TMR_W       = 20
) (
    input  logic           clk_sys,
    input  logic           rst_n,
    ps2_rd_arbiter_if.slave bus
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_DELIVER = 2'd2;

    localparam logic [TMR_W-1:0] TMR_LAST =
        (TIMEOUT_CYC == 0) ? '0 : TMR_W'(TIMEOUT_CYC - 1);

    logic [1:0]        r_state;
    logic              r_idx;
    logic              r_last_srv;
    logic [TMR_W-1:0]  r_timer;
    logic              r_hold;
    logic [1:0]        r_gnt;
    logic [1:0]        r_pkt_vld;
    logic [1:0]        r_timeout;
    logic              r_rd_en;
    logic [DATA_W-1:0] r_pkt_data;
    logic [7:0]        r_drop_cnt;

    logic w_pick;
    logic w_req_g;
    logic w_expire;
    logic w_drop;

    assign w_pick   = (bus.req == 2'b11) ? ~r_last_srv : bus.req[1];
    assign w_req_g  = bus.req[r_idx];
    assign w_expire = (TIMEOUT_CYC != 0) && (r_timer == TMR_LAST);
    assign w_drop   = bus.rd_vld && !r_rd_en;

    // An abort or timeout leaves WAIT straight to IDLE, so r_hold blocks one
    // IDLE cycle to keep rd_en low for two cycles between any two grants.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_idx      <= 1'b0;
            r_last_srv <= 1'b1;
            r_timer    <= '0;
            r_hold     <= 1'b0;
            r_gnt      <= 2'b00;
            r_pkt_vld  <= 2'b00;
            r_timeout  <= 2'b00;
            r_rd_en    <= 1'b0;
            r_pkt_data <= '0;
        end else begin
            r_timeout <= 2'b00;
            r_hold    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!r_hold && (bus.req != 2'b00)) begin
                        r_idx      <= w_pick;
                        r_last_srv <= w_pick;
                        r_timer    <= '0;
                        r_gnt      <= w_pick ? 2'b10 : 2'b01;
                        r_rd_en    <= 1'b1;
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_timer <= r_timer + 1'b1;
                    if (bus.rd_vld) begin
                        r_pkt_data <= bus.rd_data;
                        r_pkt_vld  <= r_gnt;
                        r_rd_en    <= 1'b0;
                        r_state    <= S_DELIVER;
                    end else if (!w_req_g) begin
                        r_gnt   <= 2'b00;
                        r_rd_en <= 1'b0;
                        r_hold  <= 1'b1;
                        r_state <= S_IDLE;
                    end else if (w_expire) begin
                        r_timeout <= r_gnt;
                        r_gnt     <= 2'b00;
                        r_rd_en   <= 1'b0;
                        r_hold    <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                S_DELIVER: begin
                    r_pkt_vld <= 2'b00;
                    r_gnt     <= 2'b00;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_pkt_vld <= 2'b00;
                    r_gnt     <= 2'b00;
                    r_rd_en   <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= 8'd0;
        end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign bus.gnt      = r_gnt;
    assign bus.pkt_vld  = r_pkt_vld;
    assign bus.pkt_data = r_pkt_data;
    assign bus.timeout  = r_timeout;
    assign bus.rd_en    = r_rd_en;
    assign bus.drop_cnt = r_drop_cnt;
endmodule
